data_bus_arbiter: RTL and testbench

//  Two-requester round-robin arbiter that shares the single outside_data/outside_data_valid

---
 rtl/data_bus_arbiter.sv | 149 ++++++++++++++
 tb/tb_data_bus_arbiter.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/data_bus_arbiter.sv
// data_bus_arbiter
//   Two-requester round-robin arbiter feeding the single outside_data /
//   outside_data_valid input of data_top. A grant is locked for a whole burst,
//   which ends on a beat with last or when MAX_BURST beats have been accepted.
//   Each grant is followed by one IDLE bubble cycle.
//
// Ports
//   clk                      system clock, rising edge
//   rst_n                    synchronous reset, active-high (1 = reset)
//   req0_valid/data/last     requester 0 beat offer
//   req0_ready               requester 0 beat accepted when valid & ready
//   req1_valid/data/last     requester 1 beat offer
//   req1_ready               requester 1 beat accepted when valid & ready
//   out_valid, out_data      registered beat towards data_top
//   gnt_id                   id of the current or most recent grant (registered)
module data_bus_arbiter #(
    parameter int unsigned width_top = 4,
    parameter int unsigned MAX_BURST = 8,
    parameter int unsigned CNT_W     = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req0_valid,
    input  logic [width_top-1:0] req0_data,
    input  logic                 req0_last,
    output logic                 req0_ready,
    input  logic                 req1_valid,
    input  logic [width_top-1:0] req1_data,
    input  logic                 req1_last,
    output logic                 req1_ready,
    output logic                 out_valid,
    output logic [width_top-1:0] out_data,
    output logic                 gnt_id
);

    typedef enum logic [1:0] {StIdle, StGnt0, StGnt1} state_e;

    state_e               state_q, state_d;
    logic                 rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]     beat_cnt_q, beat_cnt_d;
    logic                 out_valid_q;
    logic [width_top-1:0] out_data_q;
    logic                 gnt_id_q;

    logic                 accept;
    logic                 cur_last;
    logic [width_top-1:0] cur_data;
    logic                 burst_done;

    // State register
    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q    <= StIdle;
            rr_ptr_q   <= 1'b0;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    // Beat acceptance for whichever requester holds the grant
    always_comb begin
        accept   = 1'b0;
        cur_last = 1'b0;
        cur_data = '0;
        unique case (state_q)
            StGnt0: begin
                accept   = req0_valid;
                cur_last = req0_last;
                cur_data = req0_data;
            end
            StGnt1: begin
                accept   = req1_valid;
                cur_last = req1_last;
                cur_data = req1_data;
            end
            default: ;
        endcase
    end

    // last and the beat limit coinciding still produce a single release
    assign burst_done = accept &
                        (cur_last | (beat_cnt_q + CNT_W'(1) == CNT_W'(MAX_BURST)));

    // Next-state logic
    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        beat_cnt_d = beat_cnt_q;
        unique case (state_q)
            StIdle: begin
                if (req0_valid && req1_valid) begin
                    state_d = rr_ptr_q ? StGnt1 : StGnt0;
                end else if (req0_valid) begin
                    state_d = StGnt0;
                end else if (req1_valid) begin
                    state_d = StGnt1;
                end
            end
            StGnt0, StGnt1: begin
                if (burst_done) begin
                    state_d    = StIdle;
                    rr_ptr_d   = (state_q == StGnt0);
                    beat_cnt_d = '0;
                end else if (accept) begin
                    beat_cnt_d = beat_cnt_q + CNT_W'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Output logic
    always_comb begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        unique case (state_q)
            StGnt0:  req0_ready = 1'b1;
            StGnt1:  req1_ready = 1'b1;
            default: ;
        endcase
    end

    // Registered datapath towards data_top; data holds when no beat is accepted
    always_ff @(posedge clk) begin
        if (rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            gnt_id_q    <= 1'b0;
        end else begin
            out_valid_q <= accept;
            if (accept) begin
                out_data_q <= cur_data;
            end
            if (state_q == StIdle && state_d == StGnt0) begin
                gnt_id_q <= 1'b0;
            end else if (state_q == StIdle && state_d == StGnt1) begin
                gnt_id_q <= 1'b1;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign gnt_id    = gnt_id_q;

endmodule

// File: tb/tb_data_bus_arbiter.sv
module tb_data_bus_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req0_valid, req0_last, req0_ready;
    logic [3:0] req0_data;
    logic       req1_valid, req1_last, req1_ready;
    logic [3:0] req1_data;
    logic       out_valid;
    logic [3:0] out_data;
    logic       gnt_id;

    int passed = 0;
    int total  = 0;

    data_bus_arbiter #(
        .width_top(4),
        .MAX_BURST(8),
        .CNT_W    (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req0_valid(req0_valid),
        .req0_data (req0_data),
        .req0_last (req0_last),
        .req0_ready(req0_ready),
        .req1_valid(req1_valid),
        .req1_data (req1_data),
        .req1_last (req1_last),
        .req1_ready(req1_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .gnt_id    (gnt_id)
    );

    always #5 clk = ~clk;

    // Inputs are driven and outputs sampled 1ns after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n      = 1'b1;
        req0_valid = 1'b0; req0_data = 4'd0; req0_last = 1'b0;
        req1_valid = 1'b0; req1_data = 4'd0; req1_last = 1'b0;
        step();
        step();
        rst_n = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b exp 0", out_valid); else passed++;
        total++; if (out_data !== 4'd0) $display("FAIL reset_out_data got %0d exp 0", out_data); else passed++;
        total++; if (gnt_id !== 1'b0) $display("FAIL reset_gnt_id got %b exp 0", gnt_id); else passed++;
        total++; if ({req0_ready, req1_ready} !== 2'b00)
            $display("FAIL reset_ready got %b exp 00", {req0_ready, req1_ready}); else passed++;
    endtask

    task automatic test_single_beat();
        do_reset();
        req0_valid = 1'b1; req0_data = 4'd10; req0_last = 1'b1;
        step();
        total++; if (req0_ready !== 1'b1) $display("FAIL t1_ready got %b exp 1", req0_ready); else passed++;
        total++; if (out_valid !== 1'b0) $display("FAIL t1_no_out_yet got %b exp 0", out_valid); else passed++;
        step();
        req0_valid = 1'b0; req0_last = 1'b0;
        total++; if (out_valid !== 1'b1 || out_data !== 4'd10)
            $display("FAIL t1_out got v=%b d=%0d exp v=1 d=10", out_valid, out_data); else passed++;
        total++; if (req0_ready !== 1'b0) $display("FAIL t1_idle_ready got %b exp 0", req0_ready); else passed++;
        step();
        total++; if (out_valid !== 1'b0 || out_data !== 4'd10)
            $display("FAIL t1_hold got v=%b d=%0d exp v=0 d=10", out_valid, out_data); else passed++;
    endtask

    task automatic test_tie();
        do_reset();
        req0_valid = 1'b1; req0_data = 4'd1; req0_last = 1'b1;
        req1_valid = 1'b1; req1_data = 4'd2; req1_last = 1'b1;
        step();
        total++; if ({req0_ready, req1_ready, gnt_id} !== 3'b100)
            $display("FAIL t2_first_gnt got r0r1g=%b exp 100", {req0_ready, req1_ready, gnt_id}); else passed++;
        step();
        req0_data = 4'd3;
        total++; if (out_valid !== 1'b1 || out_data !== 4'd1)
            $display("FAIL t2_first_out got v=%b d=%0d exp v=1 d=1", out_valid, out_data); else passed++;
        step();
        total++; if ({req0_ready, req1_ready, gnt_id} !== 3'b011)
            $display("FAIL t2_second_gnt got r0r1g=%b exp 011", {req0_ready, req1_ready, gnt_id}); else passed++;
        step();
        req0_valid = 1'b0; req1_valid = 1'b0;
        total++; if (out_valid !== 1'b1 || out_data !== 4'd2)
            $display("FAIL t2_second_out got v=%b d=%0d exp v=1 d=2", out_valid, out_data); else passed++;
    endtask

    task automatic test_burst_lock();
        logic [3:0] seq [4];
        seq[0] = 4'd6; seq[1] = 4'd4; seq[2] = 4'd8; seq[3] = 4'd9;
        do_reset();
        req0_valid = 1'b1; req0_data = seq[0]; req0_last = 1'b0;
        req1_valid = 1'b1; req1_data = 4'd5; req1_last = 1'b1;
        step();
        for (int i = 0; i < 4; i++) begin
            req0_data = seq[i];
            req0_last = (i == 3);
            step();
            total++; if (out_valid !== 1'b1 || out_data !== seq[i] || req1_ready !== 1'b0)
                $display("FAIL t3_beat%0d got v=%b d=%0d r1=%b exp v=1 d=%0d r1=0",
                         i, out_valid, out_data, req1_ready, seq[i]); else passed++;
        end
        req0_valid = 1'b0; req0_last = 1'b0;
        step();
        total++; if (out_valid !== 1'b0 || req1_ready !== 1'b1 || gnt_id !== 1'b1)
            $display("FAIL t3_gnt1 got v=%b r1=%b g=%b exp v=0 r1=1 g=1",
                     out_valid, req1_ready, gnt_id); else passed++;
        step();
        req1_valid = 1'b0;
        total++; if (out_valid !== 1'b1 || out_data !== 4'd5)
            $display("FAIL t3_req1_out got v=%b d=%0d exp v=1 d=5", out_valid, out_data); else passed++;
    endtask

    task automatic test_forced_release();
        int fwd;
        fwd = 0;
        do_reset();
        req1_valid = 1'b1; req1_data = 4'd1; req1_last = 1'b0;
        step();
        req0_valid = 1'b1; req0_data = 4'd7; req0_last = 1'b1;
        for (int i = 0; i < 8; i++) begin
            req1_data = 4'(i + 1);
            step();
            if (out_valid === 1'b1 && out_data === 4'(i + 1)) fwd++;
        end
        total++; if (fwd !== 8) $display("FAIL t4_beats got %0d exp 8", fwd); else passed++;
        total++; if (req1_ready !== 1'b0) $display("FAIL t4_released got %b exp 0", req1_ready); else passed++;
        req1_data = 4'd9;
        step();
        total++; if (out_valid !== 1'b0 || req0_ready !== 1'b1 || gnt_id !== 1'b0)
            $display("FAIL t4_gnt0 got v=%b r0=%b g=%b exp v=0 r0=1 g=0",
                     out_valid, req0_ready, gnt_id); else passed++;
        step();
        req0_valid = 1'b0; req1_valid = 1'b0;
        total++; if (out_valid !== 1'b1 || out_data !== 4'd7)
            $display("FAIL t4_req0_out got v=%b d=%0d exp v=1 d=7", out_valid, out_data); else passed++;
    endtask

    task automatic test_gap();
        do_reset();
        req0_valid = 1'b1; req0_data = 4'd3; req0_last = 1'b0;
        step();
        step();
        req0_valid = 1'b0;
        total++; if (out_valid !== 1'b1 || out_data !== 4'd3)
            $display("FAIL t5_beat0 got v=%b d=%0d exp v=1 d=3", out_valid, out_data); else passed++;
        for (int i = 0; i < 2; i++) begin
            step();
            total++; if (out_valid !== 1'b0 || req0_ready !== 1'b1)
                $display("FAIL t5_gap%0d got v=%b r0=%b exp v=0 r0=1", i, out_valid, req0_ready); else passed++;
        end
        req0_valid = 1'b1; req0_data = 4'd9;
        step();
        req0_data = 4'd1; req0_last = 1'b1;
        total++; if (out_valid !== 1'b1 || out_data !== 4'd9)
            $display("FAIL t5_beat1 got v=%b d=%0d exp v=1 d=9", out_valid, out_data); else passed++;
        step();
        req0_valid = 1'b0; req0_last = 1'b0;
        total++; if (out_valid !== 1'b1 || out_data !== 4'd1 || req0_ready !== 1'b0)
            $display("FAIL t5_beat2 got v=%b d=%0d r0=%b exp v=1 d=1 r0=0",
                     out_valid, out_data, req0_ready); else passed++;
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        req0_valid = 1'b1; req0_data = 4'd12; req0_last = 1'b0;
        step();
        step();
        req0_data = 4'd10;
        step();
        total++; if (out_valid !== 1'b1 || out_data !== 4'd10)
            $display("FAIL t6_beat1 got v=%b d=%0d exp v=1 d=10", out_valid, out_data); else passed++;
        req0_data = 4'd8;
        rst_n = 1'b1;
        step();
        total++; if (out_valid !== 1'b0 || out_data !== 4'd0 || req0_ready !== 1'b0)
            $display("FAIL t6_reset got v=%b d=%0d r0=%b exp v=0 d=0 r0=0",
                     out_valid, out_data, req0_ready); else passed++;
        rst_n = 1'b0;
        req1_valid = 1'b1; req1_data = 4'd2; req1_last = 1'b1;
        step();
        total++; if ({req0_ready, req1_ready, gnt_id} !== 3'b100)
            $display("FAIL t6_tie got r0r1g=%b exp 100", {req0_ready, req1_ready, gnt_id}); else passed++;
        req0_valid = 1'b0; req1_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_beat();
        test_tie();
        test_burst_lock();
        test_forced_release();
        test_gap();
        test_reset_mid_burst();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout got running exp finished");
        $fatal(1, "timeout");
    end

endmodule
